instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
//
// PURPOSE
//  Consumer side of the PC/next-PC interface. Owns the fetch PC, issues
//  in-order word reads to instruction memory over a req/gnt/rvalid
//  handshake, and buffers returned instructions with their PCs in a
//  small FIFO. Presents them to decode through a valid/ready handshake.
//  Takes branch redirects (i_br_sel/i_pc_bru) from execute and flushes
//  wrong-path instructions, both buffered and in-flight.
//
// PARAMETERS
//  DEPTH    4             FIFO entries; also the cap on outstanding+buffered words
//  RESET_PC 32'h0000_0000 first fetch address after reset
//
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst_n        in   1   asynchronous reset, active low
//  i_br_sel       in   1   redirect strobe from execute (one-cycle pulse)
//  i_pc_bru       in   32  redirect target; bits[1:0] ignored
//  o_imem_req     out  1   read request
//  o_imem_addr    out  32  word-aligned read address
//  i_imem_gnt     in   1   request accepted this cycle
//  i_imem_rvalid  in   1   read data valid; in order, one per granted request
//  i_imem_rdata   in   32  instruction word
//  o_inst_valid   out  1   instruction available to decode
//  o_inst         out  32  instruction word
//  o_inst_pc      out  32  PC of o_inst
//  i_inst_ready   in   1   decode accepts; pop when valid & ready
//
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - fetch_pc = resp_pc = RESET_PC.
//    - outstanding = drop_cnt = 0; FIFO empty.
//    - o_imem_req = 0, o_inst_valid = 0, o_inst = 0, o_inst_pc = 0.
//    - o_imem_addr = RESET_PC.
//  - Issue:
//    - o_imem_req = !i_br_sel && (outstanding + fifo_count < DEPTH).
//    - o_imem_addr = fetch_pc.
//    - req & gnt: fetch_pc += 4 (wraps mod 2^32); outstanding++.
//    - Stalled req (gnt=0): addr held stable; req stays high unless i_br_sel.
//  - Response (i_imem_rvalid), any latency >= 1 cycle after gnt:
//    - outstanding-- always.
//    - If drop_cnt > 0: discard and drop_cnt--.
//    - Else: push {rdata, resp_pc} and resp_pc += 4.
//    - Never arrives into a full FIFO, because the credit rule prevents it.
//  - Output (show-ahead):
//    - o_inst_valid = !empty; o_inst/o_inst_pc = FIFO head.
//    - Pop on valid & ready.
//    - Push and pop in the same cycle are legal at any occupancy, full included.
//    - o_inst/o_inst_pc are don't-care when invalid; reset value is 0.
//  - Redirect (i_br_sel=1), evaluated at the clock edge:
//    - FIFO cleared; a same-cycle push and pop are both suppressed.
//    - drop_cnt <= outstanding - i_imem_rvalid (an rvalid in this cycle is discarded).
//    - fetch_pc <= resp_pc <= {i_pc_bru[31:2], 2'b00}.
//    - o_imem_req = 0 in this cycle; a stalled request may be withdrawn.
//    - o_inst_valid = 0 in the following cycle; the earliest new-target issue
//      is the following cycle.
//  - Invariants: drop_cnt <= outstanding <= DEPTH.
//    - Counters are $clog2(DEPTH+1) bits wide.
//  - Async reset mid-transfer: all state is cleared immediately.
//    - In-flight memory responses after release are a system reset error and
//      are not tolerated.
//
// STRUCTURE
//  - Shared package: RESET_PC default, XLEN = 32, INST_NOP = 32'h0000_0013.
//  - Shared package: typedef fetch_entry_t {logic [31:0] inst; logic [31:0] pc;}.
//  - Sub-module fetch_fifo: DEPTH x fetch_entry_t, show-ahead, synchronous flush.
//    - Ports: push, pop, flush, count, empty, full.
//  - Top level: fetch_pc/resp_pc registers, outstanding/drop counters, issue logic.
//
// TESTING
//  1. Reset release, gnt = 1, rvalid 1 cycle after gnt, ready = 1:
//     addrs 0x0, 0x4, 0x8 -> o_inst_pc 0x0, 0x4, 0x8 in order.
//  2. ready = 0, DEPTH = 4: exactly 4 grants, then req = 0.
//     Set ready = 1 -> 4 pops, with no loss or duplication; issue resumes at 0x10.
//  3. gnt = 0 for 3 cycles at addr 0x8: req stays 1 and addr stays 0x8.
//     gnt = 1 -> next addr 0xC.
//  4. 2 outstanding plus 1 buffered, i_br_sel with pc_bru = 0x103:
//     both late responses are dropped.
//     The next o_inst_pc = 0x100 with the rdata of the 0x100 request.
//  5. Redirect in the same cycle as rvalid and valid & ready:
//     no push, no pop, drop_cnt = outstanding - 1; the next valid is the target.
//  6. Assert i_rst_n = 0 mid-stream:
//     o_inst_valid and o_imem_req go 0 without waiting for a clock.
//     After release the first addr is RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared fetch constants and the buffered-instruction entry type
package instr_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: show-ahead instruction/PC buffer with synchronous flush
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty && !flush;
  // a full FIFO may still accept a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout = mem[rd_ptr];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: in-order instruction fetch with credit-limited issue and branch flush
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_br_sel,
  input  logic [XLEN-1:0] i_pc_bru,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  input  logic            i_inst_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] fetch_pc, resp_pc, target;
  logic [CW-1:0] outstanding, drop_cnt, fifo_count;
  logic [CW:0] in_use;
  logic fifo_empty, fifo_full, issue, push;
  fetch_entry_t din, head;
  assign target = i_pc_bru & ~32'h3;
  // credits cover both in-flight and buffered words, so a response never meets a full FIFO
  assign in_use = {1'b0, outstanding} + {1'b0, fifo_count};
  assign o_imem_req = i_rst_n && !i_br_sel && !fifo_full && in_use < (CW + 1)'(DEPTH);
  assign o_imem_addr = fetch_pc;
  assign issue = o_imem_req && i_imem_gnt;
  assign push = i_imem_rvalid && drop_cnt == '0 && !i_br_sel;
  assign din = '{inst: i_imem_rdata, pc: resp_pc};
  assign o_inst_valid = !fifo_empty;
  assign o_inst = head.inst;
  assign o_inst_pc = head.pc;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .push   (push),
    .pop    (o_inst_valid && i_inst_ready),
    .flush  (i_br_sel),
    .din    (din),
    .dout   (head),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(i_imem_rvalid);
      if (i_br_sel) begin
        fetch_pc <= target;
        resp_pc <= target;
        drop_cnt <= outstanding - CW'(i_imem_rvalid);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (i_imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        else if (i_imem_rvalid) resp_pc <= resp_pc + 32'd4;
      end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios against a latency-1 memory responder
module tb_instr_fetch_unit;
  logic i_clk = 0;
  logic i_rst_n, i_br_sel, i_imem_gnt, i_inst_ready;
  logic i_imem_rvalid = 0;
  logic [31:0] i_imem_rdata = 0;
  logic [31:0] i_pc_bru;
  logic o_imem_req, o_inst_valid;
  logic [31:0] o_imem_addr, o_inst, o_inst_pc;
  int tests = 0, fails = 0;
  bit resp_en = 1;
  logic [31:0] pend[$], issued[$], pop_pc[$], pop_inst[$];

  always #5 i_clk = ~i_clk;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_br_sel     (i_br_sel),
    .i_pc_bru     (i_pc_bru),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_gnt   (i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_inst_valid (o_inst_valid),
    .o_inst       (o_inst),
    .o_inst_pc    (o_inst_pc),
    .i_inst_ready (i_inst_ready)
  );

  // memory returns ~addr one cycle after grant; also logs grants and pops
  always @(negedge i_clk) begin
    #1;
    if (resp_en && pend.size() > 0) begin
      i_imem_rvalid = 1;
      i_imem_rdata = ~pend.pop_front();
    end else i_imem_rvalid = 0;
    #1;
    if (i_rst_n) begin
      if (o_imem_req && i_imem_gnt) begin
        pend.push_back(o_imem_addr);
        issued.push_back(o_imem_addr);
      end
      if (o_inst_valid && i_inst_ready && !i_br_sel) begin
        pop_pc.push_back(o_inst_pc);
        pop_inst.push_back(o_inst);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_reset;
    @(negedge i_clk);
    i_rst_n = 0;
    i_br_sel = 0;
    i_pc_bru = 0;
    i_imem_gnt = 0;
    i_inst_ready = 0;
    resp_en = 1;
    pend.delete();
    issued.delete();
    pop_pc.delete();
    pop_inst.delete();
    step(2);
    i_rst_n = 1;
  endtask

  task automatic test_reset;
    i_rst_n = 0;
    i_br_sel = 0;
    i_pc_bru = 0;
    i_imem_gnt = 1;
    i_inst_ready = 1;
    step(2);
    #3;
    tests++; if (o_imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", o_imem_req); end
    tests++; if (o_inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", o_inst_valid); end
    tests++; if (o_inst !== 32'h0) begin fails++; $display("FAIL reset_inst got %h exp 0", o_inst); end
    tests++; if (o_inst_pc !== 32'h0) begin fails++; $display("FAIL reset_inst_pc got %h exp 0", o_inst_pc); end
    tests++; if (o_imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", o_imem_addr); end
  endtask

  task automatic test_basic;
    do_reset;
    i_imem_gnt = 1;
    i_inst_ready = 1;
    #3;
    tests++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h0}) begin fails++; $display("FAIL basic_first_req got %b/%h exp 1/0", o_imem_req, o_imem_addr); end
    step(6);
    #3;
    tests++; if (pop_pc.size() < 3) begin fails++; $display("FAIL basic_pop_count got %0d exp >=3", pop_pc.size()); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (issued[i] !== 32'(4 * i)) begin fails++; $display("FAIL basic_addr%0d got %h exp %h", i, issued[i], 32'(4 * i)); end
      tests++; if (pop_pc[i] !== 32'(4 * i)) begin fails++; $display("FAIL basic_pc%0d got %h exp %h", i, pop_pc[i], 32'(4 * i)); end
      tests++; if (pop_inst[i] !== ~32'(4 * i)) begin fails++; $display("FAIL basic_inst%0d got %h exp %h", i, pop_inst[i], ~32'(4 * i)); end
    end
  endtask

  task automatic test_credit;
    do_reset;
    i_imem_gnt = 1;
    step(10);
    #3;
    tests++; if (issued.size() !== 4) begin fails++; $display("FAIL credit_grants got %0d exp 4", issued.size()); end
    tests++; if (o_imem_req !== 1'b0) begin fails++; $display("FAIL credit_req got %b exp 0", o_imem_req); end
    tests++; if ({o_inst_valid, o_inst_pc} !== {1'b1, 32'h0}) begin fails++; $display("FAIL credit_head got %b/%h exp 1/0", o_inst_valid, o_inst_pc); end
    @(negedge i_clk);
    i_inst_ready = 1;
    step(8);
    #3;
    tests++; if (pop_pc.size() < 5) begin fails++; $display("FAIL credit_pop_count got %0d exp >=5", pop_pc.size()); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (pop_pc[i] !== 32'(4 * i)) begin fails++; $display("FAIL credit_pc%0d got %h exp %h", i, pop_pc[i], 32'(4 * i)); end
      tests++; if (pop_inst[i] !== ~32'(4 * i)) begin fails++; $display("FAIL credit_inst%0d got %h exp %h", i, pop_inst[i], ~32'(4 * i)); end
    end
    tests++; if (issued[4] !== 32'h10) begin fails++; $display("FAIL credit_resume got %h exp 10", issued[4]); end
  endtask

  task automatic test_stall;
    do_reset;
    i_imem_gnt = 1;
    i_inst_ready = 1;
    step(2);
    i_imem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      tests++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h8}) begin fails++; $display("FAIL stall%0d got %b/%h exp 1/8", i, o_imem_req, o_imem_addr); end
      @(negedge i_clk);
    end
    i_imem_gnt = 1;
    step(2);
    #3;
    tests++; if (issued.size() < 4) begin fails++; $display("FAIL stall_grants got %0d exp >=4", issued.size()); end
    tests++; if (issued[2] !== 32'h8) begin fails++; $display("FAIL stall_addr2 got %h exp 8", issued[2]); end
    tests++; if (issued[3] !== 32'hC) begin fails++; $display("FAIL stall_addr3 got %h exp c", issued[3]); end
  endtask

  task automatic test_redirect;
    do_reset;
    i_imem_gnt = 1;
    step(2);
    resp_en = 0;
    step(1);
    i_imem_gnt = 0;
    i_br_sel = 1;
    i_pc_bru = 32'h103;
    #3;
    tests++; if (issued.size() !== 3) begin fails++; $display("FAIL redir_setup_grants got %0d exp 3", issued.size()); end
    tests++; if ({o_inst_valid, o_inst_pc} !== {1'b1, 32'h0}) begin fails++; $display("FAIL redir_setup_head got %b/%h exp 1/0", o_inst_valid, o_inst_pc); end
    tests++; if (o_imem_req !== 1'b0) begin fails++; $display("FAIL redir_req got %b exp 0", o_imem_req); end
    @(negedge i_clk);
    i_br_sel = 0;
    i_imem_gnt = 1;
    resp_en = 1;
    #3;
    tests++; if (o_inst_valid !== 1'b0) begin fails++; $display("FAIL redir_valid_after got %b exp 0", o_inst_valid); end
    tests++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h100}) begin fails++; $display("FAIL redir_target got %b/%h exp 1/100", o_imem_req, o_imem_addr); end
    step(4);
    #3;
    tests++; if ({o_inst_valid, o_inst_pc} !== {1'b1, 32'h100}) begin fails++; $display("FAIL redir_pc got %b/%h exp 1/100", o_inst_valid, o_inst_pc); end
    tests++; if (o_inst !== 32'hFFFF_FEFF) begin fails++; $display("FAIL redir_inst got %h exp fffffeff", o_inst); end
  endtask

  task automatic test_redirect_collide;
    do_reset;
    i_imem_gnt = 1;
    step(2);
    resp_en = 0;
    step(1);
    resp_en = 1;
    i_inst_ready = 1;
    i_br_sel = 1;
    i_pc_bru = 32'h200;
    #3;
    tests++; if ({o_inst_valid, o_inst_pc} !== {1'b1, 32'h0}) begin fails++; $display("FAIL coll_setup_head got %b/%h exp 1/0", o_inst_valid, o_inst_pc); end
    tests++; if (o_imem_req !== 1'b0) begin fails++; $display("FAIL coll_req got %b exp 0", o_imem_req); end
    @(negedge i_clk);
    i_br_sel = 0;
    #3;
    tests++; if (o_inst_valid !== 1'b0) begin fails++; $display("FAIL coll_valid_after got %b exp 0", o_inst_valid); end
    tests++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h200}) begin fails++; $display("FAIL coll_target got %b/%h exp 1/200", o_imem_req, o_imem_addr); end
    step(4);
    #3;
    tests++; if (pop_pc.size() < 1) begin fails++; $display("FAIL coll_pop_count got %0d exp >=1", pop_pc.size()); end
    tests++; if (pop_pc[0] !== 32'h200) begin fails++; $display("FAIL coll_pc got %h exp 200", pop_pc[0]); end
    tests++; if (pop_inst[0] !== 32'hFFFF_FDFF) begin fails++; $display("FAIL coll_inst got %h exp fffffdff", pop_inst[0]); end
  endtask

  task automatic test_async_reset;
    do_reset;
    i_imem_gnt = 1;
    i_inst_ready = 1;
    step(4);
    #3;
    tests++; if ({o_inst_valid, o_imem_req} !== 2'b11) begin fails++; $display("FAIL arst_setup got %b%b exp 11", o_inst_valid, o_imem_req); end
    i_rst_n = 0;
    #1;
    tests++; if (o_inst_valid !== 1'b0) begin fails++; $display("FAIL arst_valid got %b exp 0", o_inst_valid); end
    tests++; if (o_imem_req !== 1'b0) begin fails++; $display("FAIL arst_req got %b exp 0", o_imem_req); end
    pend.delete();
    issued.delete();
    step(2);
    i_rst_n = 1;
    #3;
    tests++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h0}) begin fails++; $display("FAIL arst_release got %b/%h exp 1/0", o_imem_req, o_imem_addr); end
    step(1);
    #3;
    tests++; if (issued.size() < 1 || issued[0] !== 32'h0) begin fails++; $display("FAIL arst_first_addr got %h exp 0", issued.size() ? issued[0] : 32'hx); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_credit;
    test_stall;
    test_redirect;
    test_redirect_collide;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
